// File: rtl/ps2_command_sequencer.sv
// PS/2 host command sequencer: issues a command byte, waits for the device ACK,
// retries on 0xFE resend, and buffers every other received byte in a small rx FIFO.
//
// state      | meaning
// S_IDLE     | ready for a host command; data-in receiver armed
// S_SEND     | command-out engine is transmitting the_command
// S_WAIT_ACK | byte sent; waiting for 0xFA/0xFE with the ACK timer running
module ps2_command_sequencer #(
  parameter int FIFO_AW     = 3,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_cmd_data,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  output logic       o_cmd_done,
  output logic       o_cmd_error,
  output logic [1:0] o_cmd_err_code,
  output logic       o_send_command,
  output logic [7:0] o_the_command,
  input  logic       i_command_was_sent,
  input  logic       i_error_communication_timed_out,
  output logic       o_wait_for_incoming_data,
  input  logic [7:0] i_received_data,
  input  logic       i_received_data_en,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  output logic       o_rx_overflow,
  input  logic       i_rx_overflow_clr
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RTY_ONE  = RW'(1);
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic [7:0] BYTE_ACK    = 8'hFA;
  localparam logic [7:0] BYTE_RESEND = 8'hFE;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_ACK} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_retry;
  logic [FIFO_AW:0] r_wr_ptr;
  logic [FIFO_AW:0] r_rd_ptr;
  logic [7:0]      r_mem [2**FIFO_AW];
  logic            r_overflow;

  logic w_empty, w_full, w_push_req, w_push, w_pop, w_drop, w_ack_byte;

  // ACK and resend bytes are consumed by the FSM only while it is waiting for them
  assign w_ack_byte = (r_state == S_WAIT_ACK) &&
                      ((i_received_data == BYTE_ACK) || (i_received_data == BYTE_RESEND));
  assign w_push_req = i_received_data_en && !w_ack_byte;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                      (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
  assign w_pop      = !w_empty && i_rx_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign o_rx_data     = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign o_rx_valid    = !w_empty;
  assign o_rx_overflow = r_overflow;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state                  <= S_IDLE;
      r_timer                  <= '0;
      r_retry                  <= '0;
      o_cmd_ready              <= 1'b1;
      o_cmd_done               <= 1'b0;
      o_cmd_error              <= 1'b0;
      o_cmd_err_code           <= 2'b00;
      o_send_command           <= 1'b0;
      o_the_command            <= 8'h00;
      o_wait_for_incoming_data <= 1'b1;
    end else begin
      o_cmd_done  <= 1'b0;
      o_cmd_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_the_command            <= i_cmd_data;
            r_retry                  <= '0;
            o_send_command           <= 1'b1;
            o_wait_for_incoming_data <= 1'b0;
            o_cmd_ready              <= 1'b0;
            r_state                  <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_error_communication_timed_out) begin
            o_cmd_error              <= 1'b1;
            o_cmd_err_code           <= 2'b01;
            o_send_command           <= 1'b0;
            o_wait_for_incoming_data <= 1'b1;
            o_cmd_ready              <= 1'b1;
            r_state                  <= S_IDLE;
          end else if (i_command_was_sent) begin
            o_send_command           <= 1'b0;
            o_wait_for_incoming_data <= 1'b1;
            r_timer                  <= TMO_LOAD;
            r_state                  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_received_data_en && (i_received_data == BYTE_ACK)) begin
            o_cmd_done  <= 1'b1;
            o_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end else if (i_received_data_en && (i_received_data == BYTE_RESEND)) begin
            if (r_retry < RTY_MAX) begin
              r_retry                  <= r_retry + RTY_ONE;
              o_send_command           <= 1'b1;
              o_wait_for_incoming_data <= 1'b0;
              r_state                  <= S_SEND;
            end else begin
              o_cmd_error    <= 1'b1;
              o_cmd_err_code <= 2'b11;
              o_cmd_ready    <= 1'b1;
              r_state        <= S_IDLE;
            end
          end else if (i_received_data_en) begin
            // a stray byte at terminal count defers the timeout by one cycle
            r_timer <= (r_timer == '0) ? r_timer : r_timer - TMO_ONE;
          end else if (r_timer == '0) begin
            o_cmd_error    <= 1'b1;
            o_cmd_err_code <= 2'b10;
            o_cmd_ready    <= 1'b1;
            r_state        <= S_IDLE;
          end else begin
            r_timer <= r_timer - TMO_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_drop)                 r_overflow <= 1'b1;
      else if (i_rx_overflow_clr) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_received_data;
  end

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Self-checking bench for ps2_command_sequencer: command table, randomized
// command outcomes and FIFO traffic against a queue model, plus corner sequences.
module tb_ps2_command_sequencer;
  localparam int T  = 300;
  localparam int MR = 2;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic [7:0] i_cmd_data = 8'h00;
  logic i_cmd_valid = 1'b0;
  logic o_cmd_ready, o_cmd_done, o_cmd_error, o_send_command, o_wait_for_incoming_data;
  logic [1:0] o_cmd_err_code;
  logic [7:0] o_the_command, o_rx_data;
  logic i_command_was_sent = 1'b0;
  logic i_error_communication_timed_out = 1'b0;
  logic [7:0] i_received_data = 8'h00;
  logic i_received_data_en = 1'b0;
  logic o_rx_valid, o_rx_overflow;
  logic i_rx_ready = 1'b0;
  logic i_rx_overflow_clr = 1'b0;

  ps2_command_sequencer #(.FIFO_AW(3), .ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_data(i_cmd_data), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_cmd_done(o_cmd_done), .o_cmd_error(o_cmd_error), .o_cmd_err_code(o_cmd_err_code),
    .o_send_command(o_send_command), .o_the_command(o_the_command),
    .i_command_was_sent(i_command_was_sent),
    .i_error_communication_timed_out(i_error_communication_timed_out),
    .o_wait_for_incoming_data(o_wait_for_incoming_data),
    .i_received_data(i_received_data), .i_received_data_en(i_received_data_en),
    .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
    .o_rx_overflow(o_rx_overflow), .i_rx_overflow_clr(i_rx_overflow_clr)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0, err_cnt = 0, rise_cnt = 0;
  logic [1:0] last_code = 2'b00;
  logic prev_send = 1'b0;
  logic [7:0] q[$];

  // pulse/edge monitor sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_cmd_done) done_cnt++;
    if (o_cmd_error) begin
      err_cnt++;
      last_code = o_cmd_err_code;
    end
    if (o_send_command && !prev_send) rise_cnt++;
    prev_send = o_send_command;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] cmd;
    int delay; int n_fe; int n_junk; bit fa; bit txf;
    bit exp_done; bit exp_err; logic [1:0] exp_code; int exp_rises; int exp_fifo;
  } vec_t;
  vec_t vt[7];

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int lim);
    int k = 0;
    while (!o_cmd_ready && k < lim) begin tick(); k++; end
    check("cmd_ready_wait", int'(o_cmd_ready), 1);
  endtask

  task automatic wait_send();
    int k = 0;
    while (!o_send_command && k < 50) begin tick(); k++; end
    check("send_command_wait", int'(o_send_command), 1);
  endtask

  task automatic do_cmd(input logic [7:0] c);
    wait_ready(50);
    i_cmd_data = c; i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    check("send_at_n1", int'(o_send_command), 1);
    check("ready_low_in_send", int'(o_cmd_ready), 0);
    check("wait_low_in_send", int'(o_wait_for_incoming_data), 0);
    check("the_command", int'(o_the_command), int'(c));
  endtask

  task automatic rx(input logic [7:0] b);
    i_received_data = b; i_received_data_en = 1'b1;
    tick();
    i_received_data_en = 1'b0;
  endtask

  task automatic pulse_sent();
    i_command_was_sent = 1'b1;
    tick();
    i_command_was_sent = 1'b0;
  endtask

  task automatic drain(input int exp_n);
    int n = 0;
    int e;
    while (o_rx_valid && n < 20) begin
      e = (q.size() > 0) ? int'(q.pop_front()) : -1;
      check("rx_data", int'(o_rx_data), e);
      i_rx_ready = 1'b1;
      tick();
      i_rx_ready = 1'b0;
      n++;
    end
    check("fifo_count", n, exp_n);
    check("rx_valid_after_drain", int'(o_rx_valid), 0);
    q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int d0 = done_cnt, e0 = err_cnt, r0 = rise_cnt;
    int fe = 0, guard = 0;
    bit fin = 0;
    logic [7:0] jb;
    do_cmd(v.cmd);
    if (v.txf) begin
      repeat (3) tick();
      i_error_communication_timed_out = 1'b1;
      tick();
      i_error_communication_timed_out = 1'b0;
    end else begin
      while (!fin && guard < 8) begin
        guard++;
        wait_send();
        repeat (2) tick();
        pulse_sent();
        repeat (v.delay) tick();
        if (guard == 1)
          for (int j = 0; j < v.n_junk; j++) begin
            jb = 8'h30 + 8'(j);
            rx(jb);
            q.push_back(jb);
          end
        if (fe < v.n_fe) begin
          rx(8'hFE);
          fe++;
          if (fe > MR) fin = 1;
        end else begin
          if (v.fa) rx(8'hFA);
          fin = 1;
        end
      end
    end
    wait_ready(T + 20);
    tick(); tick();
    check("done_pulses", done_cnt - d0, int'(v.exp_done));
    check("error_pulses", err_cnt - e0, int'(v.exp_err));
    check("send_rises", rise_cnt - r0, v.exp_rises);
    if (v.exp_err) begin
      check("err_code_pulse", int'(last_code), int'(v.exp_code));
      check("err_code_held", int'(o_cmd_err_code), int'(v.exp_code));
    end
    check("send_low_idle", int'(o_send_command), 0);
    check("wait_high_idle", int'(o_wait_for_incoming_data), 1);
    drain(v.exp_fifo);
  endtask

  initial begin
    bit early;
    int d0, e0;
    bit m_ovf, pop, drop, en, rdy, clr;
    logic [7:0] dat;
    vec_t rv;

    vt[0] = '{8'hF4, 100, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1, 0};
    vt[1] = '{8'hFF,   5, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3, 0};
    vt[2] = '{8'hFF,   5, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 3, 0};
    vt[3] = '{8'hED,  10, 0, 2, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1, 2};
    vt[4] = '{8'hF2,   0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1, 0};
    vt[5] = '{8'hF3,   0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1, 0};
    vt[6] = '{8'hEE,   7, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2, 1};

    repeat (3) tick();
    check("rst_cmd_ready", int'(o_cmd_ready), 1);
    check("rst_wait", int'(o_wait_for_incoming_data), 1);
    check("rst_send", int'(o_send_command), 0);
    check("rst_done", int'(o_cmd_done), 0);
    check("rst_error", int'(o_cmd_error), 0);
    check("rst_code", int'(o_cmd_err_code), 0);
    check("rst_the_command", int'(o_the_command), 0);
    check("rst_rx_valid", int'(o_rx_valid), 0);
    check("rst_overflow", int'(o_rx_overflow), 0);
    i_reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // randomized command outcomes predicted from the retry rule
    for (int i = 0; i < 6; i++) begin
      rv.cmd = 8'($urandom);
      rv.delay = $urandom_range(0, 20);
      rv.n_fe = $urandom_range(0, 3);
      rv.n_junk = $urandom_range(0, 2);
      rv.fa = 1'b1; rv.txf = 1'b0;
      rv.exp_err = (rv.n_fe > MR);
      rv.exp_done = !rv.exp_err;
      rv.exp_code = 2'b11;
      rv.exp_rises = ((rv.n_fe > MR) ? MR : rv.n_fe) + 1;
      rv.exp_fifo = rv.n_junk;
      run_vec(rv);
    end

    // ACK timeout lands exactly ACK_TIMEOUT cycles after command_was_sent
    do_cmd(8'hF2); wait_send(); pulse_sent();
    check("wait_high_in_wait_ack", int'(o_wait_for_incoming_data), 1);
    check("send_drops_after_sent", int'(o_send_command), 0);
    early = 0;
    repeat (T - 1) begin tick(); if (o_cmd_error) early = 1; end
    check("timeout_not_early", int'(early), 0);
    tick();
    check("timeout_error", int'(o_cmd_error), 1);
    check("timeout_code", int'(o_cmd_err_code), 2);
    tick();
    check("timeout_one_pulse", int'(o_cmd_error), 0);

    // ACK on the terminal-count cycle beats the timeout
    do_cmd(8'hF2); wait_send(); pulse_sent();
    repeat (T - 1) tick();
    rx(8'hFA);
    check("boundary_ack_done", int'(o_cmd_done), 1);
    check("boundary_ack_no_err", int'(o_cmd_error), 0);
    tick();
    check("boundary_ack_no_late_err", int'(o_cmd_error), 0);

    // tx timeout and sent strobes together: error wins
    do_cmd(8'hF0); wait_send();
    i_command_was_sent = 1'b1; i_error_communication_timed_out = 1'b1;
    tick();
    i_command_was_sent = 1'b0; i_error_communication_timed_out = 1'b0;
    check("both_strobes_error", int'(o_cmd_error), 1);
    check("both_strobes_code", int'(o_cmd_err_code), 1);
    check("both_strobes_ready", int'(o_cmd_ready), 1);
    check("both_strobes_send_low", int'(o_send_command), 0);

    // FIFO overflow and simultaneous push/pop when full
    for (int i = 1; i <= 9; i++) rx(8'(i));
    check("ovf_set", int'(o_rx_overflow), 1);
    check("ovf_head", int'(o_rx_data), 1);
    i_received_data = 8'h0A; i_received_data_en = 1'b1; i_rx_ready = 1'b1;
    tick();
    i_received_data_en = 1'b0; i_rx_ready = 1'b0;
    check("ovf_kept_on_push_pop", int'(o_rx_overflow), 1);
    for (int i = 2; i <= 8; i++) q.push_back(8'(i));
    q.push_back(8'h0A);
    drain(8);
    i_rx_overflow_clr = 1'b1; tick(); i_rx_overflow_clr = 1'b0;
    check("ovf_cleared", int'(o_rx_overflow), 0);
    for (int i = 1; i <= 8; i++) begin rx(8'(i)); q.push_back(8'(i)); end
    i_received_data = 8'h55; i_received_data_en = 1'b1; i_rx_overflow_clr = 1'b1;
    tick();
    i_received_data_en = 1'b0; i_rx_overflow_clr = 1'b0;
    check("drop_beats_clear", int'(o_rx_overflow), 1);
    i_rx_overflow_clr = 1'b1; tick(); i_rx_overflow_clr = 1'b0;
    check("ovf_cleared2", int'(o_rx_overflow), 0);
    drain(8);

    // random IDLE FIFO traffic against a queue model
    m_ovf = 0;
    for (int c = 0; c < 400; c++) begin
      check("rnd_rx_valid", int'(o_rx_valid), int'(q.size() != 0));
      if (q.size() != 0) check("rnd_rx_data", int'(o_rx_data), int'(q[0]));
      check("rnd_overflow", int'(o_rx_overflow), int'(m_ovf));
      en  = 1'($urandom_range(0, 1));
      dat = 8'($urandom);
      rdy = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      pop  = (q.size() != 0) && rdy;
      drop = en && (q.size() == 8) && !pop;
      if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
      if (pop) void'(q.pop_front());
      if (en && !drop) q.push_back(dat);
      i_received_data = dat; i_received_data_en = en;
      i_rx_ready = rdy; i_rx_overflow_clr = clr;
      tick();
    end
    i_received_data_en = 1'b0; i_rx_ready = 1'b0; i_rx_overflow_clr = 1'b0;
    drain(q.size());

    // reset during WAIT_ACK
    rx(8'h77);
    do_cmd(8'hF4); wait_send(); pulse_sent();
    repeat (5) tick();
    d0 = done_cnt; e0 = err_cnt;
    i_reset = 1'b1;
    tick();
    check("rst_mid_send_low", int'(o_send_command), 0);
    check("rst_mid_ready", int'(o_cmd_ready), 1);
    check("rst_mid_rx_valid", int'(o_rx_valid), 0);
    check("rst_mid_wait", int'(o_wait_for_incoming_data), 1);
    i_reset = 1'b0;
    repeat (4) tick();
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_error", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_command_sequencer.md
Name: ps2_command_sequencer

Overview:
- Sequences host-to-device PS/2 commands: issues the byte to the PS/2 command-out engine, then arms the PS/2 data-in receiver to collect the device's ACK.
- Handles 0xFE resend with bounded retries, and times out if no ACK arrives.
- Buffers every non-ACK received byte in a small FIFO for the processor-side register interface.
- Sits between the bus-facing PS/2 register block and the command-out / data-in engines.

Parameters:
- FIFO_AW, 3, log2 of rx FIFO depth (default depth 8).
- ACK_TIMEOUT, 1000000, clk cycles allowed between command_was_sent and the ACK byte (20 ms at 50 MHz).
- MAX_RETRY, 2, number of resends permitted after 0xFE before an error is reported.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_data  in  8  command byte from host.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_done  out  1  one-cycle pulse when the ACK (0xFA) is received.
- cmd_error  out  1  one-cycle pulse on command failure.
- cmd_err_code  out  2  valid with cmd_error; holds its value until the next error. 01 = tx timeout, 10 = ack timeout, 11 = resend limit exceeded.
- send_command  out  1  level to command-out engine.
- the_command  out  8  byte to send; registered.
- command_was_sent  in  1  pulse from command-out engine.
- error_communication_timed_out  in  1  pulse from command-out engine.
- wait_for_incoming_data  out  1  arms the data-in receiver.
- received_data  in  8  byte from data-in receiver.
- received_data_en  in  1  one-cycle strobe from data-in receiver.
- rx_data  out  8  FIFO head.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop request; pop occurs when rx_valid && rx_ready.
- rx_overflow  out  1  sticky; set when a byte is dropped.
- rx_overflow_clr  in  1  clears rx_overflow.

Behaviour:
- Reset values:
  - All outputs 0 except wait_for_incoming_data = 1 and cmd_ready = 1.
  - FSM in IDLE; FIFO emptied; retry and timeout counters cleared; cmd_err_code = 00.
- FSM states: IDLE, SEND, WAIT_ACK.
- IDLE:
  - wait_for_incoming_data = 1.
  - On accept at cycle N: the_command <= cmd_data, retry count <= 0, state -> SEND.
  - send_command is 1 from cycle N+1.
- SEND:
  - send_command = 1, wait_for_incoming_data = 0.
  - command_was_sent -> WAIT_ACK, send_command drops the next cycle, timeout counter cleared.
  - error_communication_timed_out -> cmd_error with code 01, state -> IDLE.
  - If both strobes arrive in the same cycle, the error wins.
- WAIT_ACK:
  - wait_for_incoming_data = 1; timeout counter increments each cycle.
  - received_data_en with 0xFA: cmd_done pulse, state -> IDLE. The byte is not pushed to the FIFO.
  - received_data_en with 0xFE and retry count < MAX_RETRY: retry count +1, state -> SEND with the_command unchanged. The byte is not pushed.
  - received_data_en with 0xFE and retry count == MAX_RETRY: cmd_error with code 11, state -> IDLE.
  - received_data_en with any other byte: pushed to the FIFO, stay in WAIT_ACK, timer keeps running.
  - Counter reaching ACK_TIMEOUT-1 with no strobe that cycle: cmd_error with code 10, state -> IDLE. A strobe in the same cycle takes priority over the timeout.
- cmd_done and cmd_error are registered; each pulses in the cycle after the triggering event.
- FIFO push rules:
  - In IDLE and SEND, every received_data_en strobe is pushed.
  - Push when full is dropped and sets rx_overflow, unless a pop occurs in the same cycle; then push and pop both succeed.
  - Push and pop in the same cycle when empty: the push succeeds and rx_valid is 1 the next cycle. There is no fall-through.
  - rx_data is valid the cycle after the push.
- FIFO pointers are FIFO_AW+1 bits and wrap naturally. Full when the MSBs differ and the low bits are equal.
- rx_overflow: rx_overflow_clr clears it; if a drop occurs in the same cycle as the clear, the flag stays set.
- Reset asserted mid-command forces IDLE immediately with send_command = 0. No cmd_done or cmd_error is generated.
- cmd_valid while cmd_ready = 0 is ignored; the host must hold cmd_valid.

Test Plan:
- Send 0xF4; model drives command_was_sent, then 0xFA after 100 cycles -> send_command high from N+1 until sent, one cmd_done, FIFO empty, cmd_ready back high.
- Send 0xFF; device answers 0xFE, 0xFE, 0xFA -> send_command reasserted twice, cmd_done once. Then answer 0xFE three times -> cmd_error with code 11.
- Send 0xF2; model never replies -> cmd_error with code 10 exactly ACK_TIMEOUT cycles after command_was_sent. With a 0xFA strobe on that same cycle -> cmd_done and no error.
- In IDLE, push 9 bytes 0x01..0x09 with rx_ready = 0 -> FIFO holds 0x01..0x08 and rx_overflow = 1. Push 0x0A with a simultaneous pop -> accepted, rx_overflow unchanged. Drain yields 0x02..0x08, 0x0A.
- In SEND, pulse error_communication_timed_out together with command_was_sent -> cmd_error with code 01, state IDLE.
- Assert reset during WAIT_ACK -> next cycle send_command = 0, cmd_ready = 1, rx_valid = 0, no cmd_done or cmd_error pulse.
